tach_period: RTL and testbench

- Measures motor tachometer period for one BDC motor channel. Instantiated three times in root, one per tach0/tach1/tach2 pair.
- Synchronizes the 2-bit quadrature tach input, decodes direction, and times successive rising edges of channel A with a prescaled counter.
- Presents a 16-bit period as two SPI-readable bytes (motor register offsets 0 and 1), with a coherent hi-byte shadow.

---
 rtl/tach_period_pkg.sv | 31 +++
 rtl/tach_sync.sv | 37 +++
 rtl/tach_period.sv | 134 +++++++++++++
 tb/tb_tach_period.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tach_period_pkg.sv
// Shared constants and helpers for the tachometer period channel.
package tach_period_pkg;

    // Period counter width. The two-byte motor register map assumes 16;
    // narrower widths are zero-extended into the same byte map.
    localparam int TACH_CNTW     = 16;
    // Default clk cycles per period-counter tick.
    localparam int TACH_PRESCALE = 8;

    // Byte offsets of the period inside a motor register block.
    localparam int TACH_LO = 0;
    localparam int TACH_HI = 1;

    // Classification of one clk step of the synchronized quadrature pair.
    typedef enum logic [1:0] {
        QT_HOLD    = 2'd0,
        QT_STEP    = 2'd1,
        QT_ILLEGAL = 2'd2
    } quad_t;

    // A legal quadrature signal changes at most one bit per sample.
    function automatic quad_t quad_classify(input logic [1:0] prev,
                                            input logic [1:0] curr);
        logic [1:0] diff;
        diff = prev ^ curr;
        if (diff == 2'b00) return QT_HOLD;
        if (diff == 2'b11) return QT_ILLEGAL;
        return QT_STEP;
    endfunction

endpackage

// File: rtl/tach_sync.sv
// Two-flop synchronizer for an asynchronous input bus, plus a
// previous-sample register and rising-edge detect on bit 0.
module tach_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_prev,
    output logic         o_rise_a
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    // Synchronizer stages followed by the one-clk-old copy used for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage load the old
            // value of the stage before it, which is what forms the pipeline.
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync   = r_sync;
    assign o_prev   = r_prev;
    assign o_rise_a = r_sync[0] & ~r_prev[0];

endmodule

// File: rtl/tach_period.sv
// Tachometer period measurement for one BDC motor channel: synchronizes
// the quadrature pair, decodes direction, times channel-A rising edges
// with a prescaled saturating counter and exposes the period as two bytes.
module tach_period
    import tach_period_pkg::*;
#(
    parameter int CNTW     = TACH_CNTW,
    parameter int PRESCALE = TACH_PRESCALE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] tach,
    input  logic       rd_lo,
    input  logic       clr_err,
    output logic [7:0] period_lo,
    output logic [7:0] period_hi,
    output logic       dir,
    output logic       valid,
    output logic       stall,
    output logic       err
);

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   C_PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CNTW-1:0] C_MAX      = '1;
    localparam logic [CNTW-1:0] C_NEAR_MAX = C_MAX - 1'b1;

    logic [1:0]      w_sync;
    logic [1:0]      w_prev;
    logic            w_rise_a;
    logic            w_tick;
    logic            w_cnt_inc;
    logic [CNTW-1:0] w_cnt_next;
    logic [CNTW-1:0] w_capture;
    logic [15:0]     w_period_ext;

    logic [PW-1:0]   r_pre;
    logic [CNTW-1:0] r_counter;
    logic [CNTW-1:0] r_period;
    logic [7:0]      r_hi_shadow;
    logic            r_armed;
    logic            r_dir;
    logic            r_valid;
    logic            r_stall;
    logic            r_err;

    tach_sync #(.W(2)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .i_async  (tach),
        .o_sync   (w_sync),
        .o_prev   (w_prev),
        .o_rise_a (w_rise_a)
    );

    assign w_tick     = (r_pre == C_PRE_LAST);
    assign w_cnt_inc  = w_tick && (r_counter != C_MAX);
    assign w_cnt_next = r_counter + 1'b1;
    // A tick landing on the edge clk still belongs to the period that ends.
    assign w_capture  = w_cnt_inc ? w_cnt_next : r_counter;

    // Prescaler: free-running 0..PRESCALE-1, realigned to every A edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_rise_a || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Period measurement: capture on A edges, saturate into stall when slow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= '0;
            r_period  <= '0;
            r_armed   <= 1'b0;
            r_dir     <= 1'b0;
            r_valid   <= 1'b0;
            r_stall   <= 1'b0;
        end else if (w_rise_a) begin
            // B low at an A rise means A leads B: forward.
            r_dir     <= ~w_sync[1];
            r_counter <= '0;
            r_armed   <= 1'b1;
            // The first edge after reset or stall only opens a measurement.
            if (r_armed) begin
                r_period <= w_capture;
                r_valid  <= 1'b1;
                r_stall  <= 1'b0;
            end
        end else if (w_cnt_inc) begin
            r_counter <= w_cnt_next;
            if (r_counter == C_NEAR_MAX) begin
                r_period <= C_MAX;
                r_stall  <= 1'b1;
                r_valid  <= 1'b0;
                r_armed  <= 1'b0;
            end
        end
    end

    // Sticky illegal-transition flag; a new error beats a same-clk clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (quad_classify(w_prev, w_sync) == QT_ILLEGAL) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign w_period_ext = 16'(r_period);

    // High-byte shadow: loads the period_reg value the SPI sees on period_lo
    // in the same clk, so a coincident period update cannot split the pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi_shadow <= '0;
        end else if (rd_lo) begin
            r_hi_shadow <= w_period_ext[8*TACH_HI +: 8];
        end
    end

    assign period_lo = w_period_ext[8*TACH_LO +: 8];
    assign period_hi = r_hi_shadow;
    assign dir       = r_dir;
    assign valid     = r_valid;
    assign stall     = r_stall;
    assign err       = r_err;

endmodule

// File: tb/tb_tach_period.sv
// Self-checking bench for tach_period: table-driven and randomized
// quadrature periods against an arithmetic reference, plus hand-written
// sequences for reset, coherency, error flag and saturation.
module tb_tach_period;

    localparam int P_MAIN = 8;
    localparam int P_SAT  = 2;

    logic       clk;
    logic       reset;
    logic [1:0] tach;
    logic       rd_lo;
    logic       clr_err;

    logic [7:0] period_lo, period_hi;
    logic       dir, valid, stall, err;
    logic [7:0] s_period_lo, s_period_hi;
    logic       s_dir, s_valid, s_stall, s_err;

    int n_checks = 0;
    int n_errors = 0;

    // Production configuration.
    tach_period #(.CNTW(16), .PRESCALE(P_MAIN)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .tach      (tach),
        .rd_lo     (rd_lo),
        .clr_err   (clr_err),
        .period_lo (period_lo),
        .period_hi (period_hi),
        .dir       (dir),
        .valid     (valid),
        .stall     (stall),
        .err       (err)
    );

    // Narrow, fast-saturating copy so the stall path is reachable quickly.
    tach_period #(.CNTW(8), .PRESCALE(P_SAT)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .tach      (tach),
        .rd_lo     (rd_lo),
        .clr_err   (clr_err),
        .period_lo (s_period_lo),
        .period_hi (s_period_hi),
        .dir       (s_dir),
        .valid     (s_valid),
        .stall     (s_stall),
        .err       (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned len;
        bit          fwd;
        logic [15:0] exp_period;
        bit          exp_dir;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a period of len clk counts len/prescale ticks, and a
    // period long enough to reach the counter maximum is a stall instead.
    function automatic logic [15:0] model_period(input int unsigned len, input int unsigned pre,
                                                 input int unsigned maxv);
        int unsigned ticks;
        ticks = len / pre;
        return (ticks >= maxv) ? 16'(maxv) : 16'(ticks);
    endfunction

    // Raise A at the current negedge, let it reach period_reg, then read
    // the low byte so period_hi shows the matching shadow. Takes 4 clk.
    task automatic rise_a();
        tach[0] = 1'b1;
        repeat (3) @(negedge clk);
        rd_lo = 1'b1;
        @(negedge clk);
        rd_lo = 1'b0;
    endtask

    // Remainder of one quadrature cycle of len clk after rise_a. Forward:
    // B rises a quarter after A; reverse: B falls a quarter after A.
    task automatic rest(input int unsigned len, input bit fwd);
        int unsigned q;
        q = len / 4;
        repeat (q - 4) @(negedge clk);
        tach[1] = fwd;
        repeat (q) @(negedge clk);
        tach[0] = 1'b0;
        repeat (q) @(negedge clk);
        tach[1] = ~fwd;
        repeat (len - 3 * q) @(negedge clk);
    endtask

    initial begin
        logic [15:0] exp_p;
        int unsigned len;
        bit          fwd;

        vecs[0] = '{len: 1000, fwd: 1'b1, exp_period: 16'h007D, exp_dir: 1'b1};
        vecs[1] = '{len: 1000, fwd: 1'b0, exp_period: 16'h007D, exp_dir: 1'b0};
        vecs[2] = '{len: 1000, fwd: 1'b1, exp_period: 16'h007D, exp_dir: 1'b1};
        vecs[3] = '{len:  800, fwd: 1'b1, exp_period: 16'h0064, exp_dir: 1'b1};
        vecs[4] = '{len: 4088, fwd: 1'b0, exp_period: 16'h01FF, exp_dir: 1'b0};
        vecs[5] = '{len: 4096, fwd: 1'b1, exp_period: 16'h0200, exp_dir: 1'b1};
        vecs[6] = '{len:   20, fwd: 1'b1, exp_period: 16'h0002, exp_dir: 1'b1};
        vecs[7] = '{len: 2600, fwd: 1'b0, exp_period: 16'h0145, exp_dir: 1'b0};

        // Reset held while the tach pins toggle.
        reset   = 1'b1;
        rd_lo   = 1'b0;
        clr_err = 1'b0;
        tach    = 2'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_err_toggle", 32'(err), 32'd0);
            tach = 2'($urandom);
        end
        tach = 2'b00;
        @(negedge clk);
        check("rst_lo",    32'(period_lo), 32'd0);
        check("rst_hi",    32'(period_hi), 32'd0);
        check("rst_dir",   32'(dir),       32'd0);
        check("rst_valid", 32'(valid),     32'd0);
        check("rst_stall", 32'(stall),     32'd0);
        check("rst_err",   32'(err),       32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // First edge only arms the measurement.
        rise_a();
        check("first_valid", 32'(valid),     32'd0);
        check("first_lo",    32'(period_lo), 32'd0);

        // Table-driven periods.
        for (int i = 0; i < 8; i++) begin
            rest(vecs[i].len, vecs[i].fwd);
            rise_a();
            check($sformatf("tbl%0d_lo", i),    32'(period_lo), 32'(vecs[i].exp_period[7:0]));
            check($sformatf("tbl%0d_hi", i),    32'(period_hi), 32'(vecs[i].exp_period[15:8]));
            check($sformatf("tbl%0d_dir", i),   32'(dir),       32'(vecs[i].exp_dir));
            check($sformatf("tbl%0d_valid", i), 32'(valid),     32'd1);
        end

        // Randomized periods against the arithmetic reference.
        for (int i = 0; i < 8; i++) begin
            len   = $urandom_range(20, 2000);
            fwd   = 1'($urandom_range(0, 1));
            exp_p = model_period(len, P_MAIN, 32'hFFFF);
            rest(len, fwd);
            rise_a();
            check($sformatf("rnd%0d_lo", i),  32'(period_lo), 32'(exp_p[7:0]));
            check($sformatf("rnd%0d_hi", i),  32'(period_hi), 32'(exp_p[15:8]));
            check($sformatf("rnd%0d_dir", i), 32'(dir),       32'(fwd));
        end

        // Coherent read: 0x01FF then 0x0200 with rd_lo on the update clk.
        rest(4088, 1'b1);
        rise_a();
        check("coh_pre", 32'({period_hi, period_lo}), 32'h01FF);
        rest(4096, 1'b1);
        tach[0] = 1'b1;
        repeat (2) @(negedge clk);
        rd_lo = 1'b1;
        check("coh_lo_on_update", 32'(period_lo), 32'hFF);
        @(negedge clk);
        check("coh_hi_on_update", 32'(period_hi), 32'h01);
        check("coh_lo_after",     32'(period_lo), 32'h00);
        @(negedge clk);
        rd_lo = 1'b0;
        check("coh_hi_late", 32'(period_hi), 32'h02);

        // Illegal transition, sticky flag, clear and clear/error collision.
        repeat (5) @(negedge clk);
        check("err_before", 32'(err), 32'd0);
        tach = ~tach;
        repeat (4) @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clr", 32'(err), 32'd0);
        tach = ~tach;
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clr_collide", 32'(err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clr2", 32'(err), 32'd0);

        // Reset in the middle of a measurement.
        tach[0] = 1'b0;
        repeat (5) @(negedge clk);
        tach[1] = 1'b0;
        repeat (5) @(negedge clk);
        rise_a();
        repeat (300) @(negedge clk);
        tach  = 2'b00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_valid", 32'(valid),     32'd0);
        check("mid_rst_lo",    32'(period_lo), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        rise_a();
        check("post_rst_first_valid", 32'(valid), 32'd0);
        rest(800, 1'b1);
        rise_a();
        check("post_rst_lo",    32'(period_lo), 32'h64);
        check("post_rst_hi",    32'(period_hi), 32'h00);
        check("post_rst_valid", 32'(valid),     32'd1);

        // Saturation on the narrow instance (max 0xFF after 510 clk).
        rest(600, 1'b1);
        check("sat_stall", 32'(s_stall), 32'd1);
        check("sat_valid", 32'(s_valid), 32'd0);
        rd_lo = 1'b1;
        @(negedge clk);
        rd_lo = 1'b0;
        check("sat_lo", 32'(s_period_lo), 32'hFF);
        check("sat_hi", 32'(s_period_hi), 32'h00);
        repeat (3) @(negedge clk);
        rise_a();
        check("sat_first_valid", 32'(s_valid), 32'd0);
        check("sat_first_stall", 32'(s_stall), 32'd1);
        rest(100, 1'b1);
        rise_a();
        exp_p = model_period(100, P_SAT, 32'hFF);
        check("sat_recover_lo",    32'(s_period_lo), 32'(exp_p[7:0]));
        check("sat_recover_valid", 32'(s_valid),     32'd1);
        check("sat_recover_stall", 32'(s_stall),     32'd0);
        exp_p = model_period(100, P_MAIN, 32'hFFFF);
        check("main_short_lo", 32'(period_lo), 32'(exp_p[7:0]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
